game_phase_ctrl: RTL

- Top-level game sequencer for the wizard game.
- Owns the 1-second timebase and walks the screens in order: logo, mode select, play/tutorial, scoreboard, play-again.
- Drives the screen-select flags read by the VGA mux and the power-up enables read by the sprite/score logic.
- Schedules the snitch and time-turner power-up windows inside the play round from a latched random word.

---
 rtl/game_phase_ctrl_if.sv | 40 ++++
 rtl/game_phase_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/game_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_phase_ctrl_if : game sequencer control/status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface game_phase_ctrl_if;
  logic        mode_valid;
  logic [1:0]  mode;
  logic        end_game_early;
  logic        tutorial_done;
  logic        restart;
  logic [31:0] random;
  logic        pause;
  logic [2:0]  phase;
  logic        logo;
  logic        select_mode_screen;
  logic        game_active;
  logic        end_of_game;
  logic        play_again;
  logic        two_player;
  logic [7:0]  seconds_left;
  logic        sec_tick;
  logic        snitch_powerup;
  logic        time_turner_on;

  modport slave (
    input  mode_valid, mode, end_game_early, tutorial_done, restart, random, pause,
    output phase, logo, select_mode_screen, game_active, end_of_game, play_again,
           two_player, seconds_left, sec_tick, snitch_powerup, time_turner_on
  );

  modport master (
    output mode_valid, mode, end_game_early, tutorial_done, restart, random, pause,
    input  phase, logo, select_mode_screen, game_active, end_of_game, play_again,
           two_player, seconds_left, sec_tick, snitch_powerup, time_turner_on
  );
endinterface

`default_nettype wire

// File: rtl/game_phase_ctrl.sv
// ---------------------------------------------------------------------------
// game_phase_ctrl : screen sequencer, 1 s timebase and power-up scheduler.
// Optional pause support is built when PAUSE_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_phase_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int LOGO_SEC      = 5,
  parameter int GAME_SEC      = 60,
  parameter int SCORE_SEC     = 4,
  parameter int PWR_LEN_SEC   = 4
) (
  input  wire logic           clock,
  input  wire logic           reset,
  game_phase_ctrl_if.slave    bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [2:0] LOGO     = 3'd0;
  localparam logic [2:0] SELECT   = 3'd1;
  localparam logic [2:0] PLAY     = 3'd2;
  localparam logic [2:0] TUTORIAL = 3'd3;
  localparam logic [2:0] SCORE    = 3'd4;
  localparam logic [2:0] AGAIN    = 3'd5;

  logic [2:0]    r_phase;
  logic [2:0]    w_phase_nxt;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_sec;
  logic [7:0]    r_secs_left;
  logic          r_two_player;
  logic [7:0]    r_s;
  logic [7:0]    r_t;
  logic          r_snitch;
  logic          r_tt;
  logic          w_run;
  logic          w_tick;
  logic          w_trans;
  logic          w_play_entry;
  logic [8:0]    w_s_raw;
  logic [8:0]    w_t_raw;
  logic [7:0]    w_s;
  logic [7:0]    w_t;
  logic          w_snitch_win;
  logic          w_tt_win;
  logic          w_unused;

`ifdef PAUSE_EN
  logic r_paused;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_paused <= 1'b0;
    end else if (w_trans) begin
      r_paused <= 1'b0;
    end else if (r_phase == PLAY && bus.pause) begin
      r_paused <= ~r_paused;
    end
  end

  assign w_run = ~r_paused;
`else
  logic w_unused_pause;
  assign w_unused_pause = bus.pause;
  assign w_run          = 1'b1;
`endif

  assign w_unused = ^{bus.random[31:13], bus.random[7:5]};

  assign w_tick = w_run && (r_presc == PW'(TICKS_PER_SEC - 1));

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      LOGO:     if (w_tick && r_sec == 8'(LOGO_SEC - 1)) w_phase_nxt = SELECT;
      SELECT:   if (bus.mode_valid && bus.mode != 2'd3)
                  w_phase_nxt = (bus.mode == 2'd2) ? TUTORIAL : PLAY;
      PLAY:     if (bus.end_game_early) w_phase_nxt = SCORE;
                else if (w_tick && r_secs_left <= 8'd1) w_phase_nxt = SCORE;
      TUTORIAL: if (bus.tutorial_done || bus.end_game_early) w_phase_nxt = AGAIN;
      SCORE:    if (w_tick && r_sec == 8'(SCORE_SEC - 1)) w_phase_nxt = AGAIN;
      AGAIN:    if (bus.restart) w_phase_nxt = SELECT;
      default:  w_phase_nxt = LOGO;
    endcase
  end

  assign w_trans      = (w_phase_nxt != r_phase);
  assign w_play_entry = (r_phase == SELECT) && (w_phase_nxt == PLAY);

  // Window ends are clamped so a window never starts at or beyond the round length.
  assign w_s_raw = 9'(PWR_LEN_SEC) + {4'd0, bus.random[4:0]};
  assign w_t_raw = 9'(PWR_LEN_SEC) + {4'd0, bus.random[12:8]};
  assign w_s     = (w_s_raw >= 9'(GAME_SEC)) ? 8'(GAME_SEC - 1) : w_s_raw[7:0];
  assign w_t     = (w_t_raw >= 9'(GAME_SEC)) ? 8'(GAME_SEC - 1) : w_t_raw[7:0];

  assign w_snitch_win = (r_secs_left > (r_s - 8'(PWR_LEN_SEC))) && (r_secs_left <= r_s);
  assign w_tt_win     = (r_secs_left > (r_t - 8'(PWR_LEN_SEC))) && (r_secs_left <= r_t)
                        && !r_two_player && !w_snitch_win;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase      <= LOGO;
      r_presc      <= '0;
      r_sec        <= 8'd0;
      r_secs_left  <= 8'd0;
      r_two_player <= 1'b0;
      r_s          <= 8'd0;
      r_t          <= 8'd0;
      r_snitch     <= 1'b0;
      r_tt         <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;

      if (w_trans) begin
        r_presc <= '0;
        r_sec   <= 8'd0;
      end else if (w_run) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_sec <= r_sec + 8'd1;
      end

      if (w_play_entry) begin
        r_secs_left  <= 8'(GAME_SEC);
        r_two_player <= bus.mode[0];
        r_s          <= w_s;
        r_t          <= w_t;
      end else if (r_phase == PLAY && !bus.end_game_early && w_tick && r_secs_left != 8'd0) begin
        r_secs_left <= r_secs_left - 8'd1;
      end

      if (w_run) begin
        r_snitch <= (r_phase == PLAY) && w_snitch_win;
        r_tt     <= (r_phase == PLAY) && w_tt_win;
      end
    end
  end

  assign bus.phase              = r_phase;
  assign bus.logo               = (r_phase == LOGO);
  assign bus.select_mode_screen = (r_phase == SELECT);
  assign bus.game_active        = (r_phase == PLAY) || (r_phase == TUTORIAL);
  assign bus.end_of_game        = (r_phase == SCORE);
  assign bus.play_again         = (r_phase == AGAIN);
  assign bus.two_player         = r_two_player;
  assign bus.seconds_left       = r_secs_left;
  assign bus.sec_tick           = w_tick;
  // Gating keeps the last PLAY-cycle window value from leaking into SCORE.
  assign bus.snitch_powerup     = r_snitch && (r_phase == PLAY);
  assign bus.time_turner_on     = r_tt && (r_phase == PLAY);

endmodule

`default_nettype wire
